cronometro_lap: RTL and testbench
=================================

# cronometro_lap

Parametrised stopwatch/countdown core for the chronometer datapath. Counts directly in mixed radix (ms 0–999, s 0–59, min 0–59, hr 0–HR_MOD-1), so no separate binary-to-watch conversion stage is needed. Adds what the plain N-bit counter lacks:
- a programmable tick prescaler,
- up/down modes with preset load,
- a countdown-done flag,
- a wrap pulse,
- lap freeze.

It sits between the system clock and the display/driver logic.

## Interface
- DIV, 1: NEclk cycles per count tick (≥1).
- HR_BITS, 4: width of hours field.
- HR_MOD, 10: hour modulus (≤ 2^HR_BITS).

- NEclk  in  1  system clock; all state updates on its falling edge.
- Nreset  in  1  asynchronous, active-low reset.
- Enable  in  1  run (level); prescaler and counting frozen while low.
- Clear  in  1  synchronous clear.
- Load  in  1  synchronous preset load.
- Down  in  1  0 = count up, 1 = count down.
- Lap  in  1  one-cycle pulse, toggles lap freeze.
- pre_ms  in  10  preset milliseconds.
- pre_s  in  6  preset seconds.
- pre_min  in  6  preset minutes.
- pre_hr  in  HR_BITS  preset hours.
- ms  out  10  displayed milliseconds.
- s  out  6  displayed seconds.
- min  out  6  displayed minutes.
- hr  out  HR_BITS  displayed hours.
- lap_active  out  1  outputs show frozen lap value.
- done  out  1  countdown reached zero (sticky).
- wrap  out  1  one-cycle pulse on up-count rollover.

## Operation
- Prescaler `pc`, 0..DIV-1:
  - Advances only when Enable=1.
  - tick = Enable & (pc == DIV-1); pc returns to 0 on tick.
  - With DIV=1, every enabled edge is a tick.
- Live counter fields `cms`, `cs`, `cmin`, `chr` update only on tick.
- Up mode (Down=0):
  - ms increments; carry at 999→0 into s, 59→0 into min, 59→0 into hr.
  - HR_MOD-1 rollover → all fields 0 and wrap=1 for that one cycle.
- Down mode (Down=1):
  - ms decrements; borrow at 0→999 from s, 0→59 from min, 0→59 from hr.
  - The tick that makes all fields 0 sets done=1.
  - A tick while all fields are 0 leaves the count at 0 and sets done=1. Never wraps to the maximum.
- Priority per edge: Clear > Load > tick. Lap is handled independently of all three.
- Clear:
  - Fields, pc, done, wrap and lap_active all go to 0.
  - Overrides a Lap sampled on the same edge.
- Load:
  - Fields take the preset values; pc=0, done=0.
  - Out-of-range presets are clamped: ms→999, s/min→59, hr→HR_MOD-1.
  - lap_active is unchanged.
- Lap:
  - lap_active=0: capture the pre-edge live fields into lap registers and set lap_active=1. Counting continues underneath.
  - lap_active=1: clear lap_active.
- Outputs ms/s/min/hr = lap registers when lap_active, else live fields (combinational mux of registers).
- Down toggled mid-run takes effect on the next tick. It does not clear done.

## Timing
- Nreset low: asynchronously, with no clock edge, all fields, pc, lap registers, lap_active, done and wrap go to 0.
- Count latency: a tick sampled at a falling edge is visible on the outputs immediately after that edge.
- done and wrap are registered and change on the same edge as the count.
- wrap is high for exactly one NEclk cycle.
- Enable low: pc and the fields hold, no tick. Re-asserting Enable resumes from the held pc, so no partial-period loss.
- Lap and tick on the same edge: the lap register gets the pre-tick value; the live count advances.
- Load and Enable on the same edge: the load wins and the prescaler restarts. The first tick follows DIV enabled cycles later.
- Nreset released mid-operation: counting resumes from all-zero on the first falling edge after release.

## Test plan
- Up, DIV=1: reset, Enable=1 for 1000 edges → ms=0, s=1. After 60000 edges → min=1, s=0, ms=0.
- Wrap, HR_MOD=10: Load 9:59:59.999 with Down=0, then 1 tick → all fields 0, wrap=1 for one cycle, then 0.
- Countdown: Load 0:00:01.002 with Down=1, Enable=1:
  - After 1002 ticks → all 0, done=1.
  - 5 more ticks → still 0, done=1.
  - Clear → done=0.
- Lap: count at 250 when Lap pulses → outputs hold 250 with lap_active=1 while counting continues. Lap pulse at the 100th following edge → lap_active=0, outputs show 351.
- Prescaler, DIV=4:
  - ms increments every 4th enabled edge.
  - Drop Enable after 2 cycles of a period for 10 edges → no change. Re-enable → ms increments after 2 more edges.
- Async reset: at count 0:00:03.500 with lap_active=1, drop Nreset between edges → all outputs, done and lap_active go to 0 immediately, with no clock edge.

Source files
------------

// File: rtl/cronometro_lap_if.sv
// Control, preset and display signals of the cronometro_lap stopwatch core.
// The master side drives controls and presets; the slave (the core) drives the display.
interface cronometro_lap_if #(
  parameter int HR_BITS = 4
);
  logic               Enable;
  logic               Clear;
  logic               Load;
  logic               Down;
  logic               Lap;
  logic [9:0]         pre_ms;
  logic [5:0]         pre_s;
  logic [5:0]         pre_min;
  logic [HR_BITS-1:0] pre_hr;
  logic [9:0]         ms;
  logic [5:0]         s;
  logic [5:0]         min;
  logic [HR_BITS-1:0] hr;
  logic               lap_active;
  logic               done;
  logic               wrap;

  modport master (
    output Enable, Clear, Load, Down, Lap, pre_ms, pre_s, pre_min, pre_hr,
    input  ms, s, min, hr, lap_active, done, wrap
  );

  modport slave (
    input  Enable, Clear, Load, Down, Lap, pre_ms, pre_s, pre_min, pre_hr,
    output ms, s, min, hr, lap_active, done, wrap
  );
endinterface

// File: rtl/cronometro_lap.sv
// Mixed-radix stopwatch/countdown (hr:min:s.ms) with tick prescaler, preset load,
// sticky countdown-done, rollover pulse and lap freeze. State moves on the falling clock edge.
module cronometro_lap #(
  parameter int DIV     = 1,
  parameter int HR_BITS = 4,
  parameter int HR_MOD  = 10
) (
  input  logic                  NEclk,
  input  logic                  Nreset,
  cronometro_lap_if.slave       bus
);

  localparam int                 PC_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PC_W-1:0]    PC_LAST = PC_W'(DIV - 1);
  localparam logic [HR_BITS-1:0] HR_LAST = HR_BITS'(HR_MOD - 1);

  typedef struct packed {
    logic [HR_BITS-1:0] hr;
    logic [5:0]         min;
    logic [5:0]         s;
    logic [9:0]         ms;
  } time_t;

  time_t           cnt_q, cnt_d;
  time_t           lap_q, lap_d;
  time_t           preset, up_next, dn_next;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            lap_active_q, lap_active_d;
  logic            done_q, done_d;
  logic            wrap_q, wrap_d;
  logic            up_wrap;
  logic            tick;

  assign tick = bus.Enable && (pc_q == PC_LAST);

  // Out-of-range presets saturate to the largest legal value of each field.
  assign preset.ms  = (bus.pre_ms  > 10'd999) ? 10'd999 : bus.pre_ms;
  assign preset.s   = (bus.pre_s   > 6'd59)   ? 6'd59   : bus.pre_s;
  assign preset.min = (bus.pre_min > 6'd59)   ? 6'd59   : bus.pre_min;
  assign preset.hr  = (bus.pre_hr  > HR_LAST) ? HR_LAST : bus.pre_hr;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    up_next = cnt_q;
    up_wrap = 1'b0;
    if (cnt_q.ms != 10'd999) begin
      up_next.ms = cnt_q.ms + 10'd1;
    end else begin
      up_next.ms = '0;
      if (cnt_q.s != 6'd59) begin
        up_next.s = cnt_q.s + 6'd1;
      end else begin
        up_next.s = '0;
        if (cnt_q.min != 6'd59) begin
          up_next.min = cnt_q.min + 6'd1;
        end else begin
          up_next.min = '0;
          if (cnt_q.hr != HR_LAST) begin
            up_next.hr = cnt_q.hr + 1'b1;
          end else begin
            up_next.hr = '0;
            up_wrap    = 1'b1;
          end
        end
      end
    end
  end

  // Countdown saturates at zero; once ms, s and min are all zero, hr must be nonzero here.
  always_comb begin
    dn_next = cnt_q;
    if (cnt_q != '0) begin
      if (cnt_q.ms != '0) begin
        dn_next.ms = cnt_q.ms - 10'd1;
      end else begin
        dn_next.ms = 10'd999;
        if (cnt_q.s != '0) begin
          dn_next.s = cnt_q.s - 6'd1;
        end else begin
          dn_next.s = 6'd59;
          if (cnt_q.min != '0) begin
            dn_next.min = cnt_q.min - 6'd1;
          end else begin
            dn_next.min = 6'd59;
            dn_next.hr  = cnt_q.hr - 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    cnt_d        = cnt_q;
    lap_d        = lap_q;
    pc_d         = pc_q;
    lap_active_d = lap_active_q;
    done_d       = done_q;
    wrap_d       = 1'b0;

    // Lap samples the pre-edge live count, independent of any tick on the same edge.
    if (bus.Lap) begin
      if (!lap_active_q) begin
        lap_d        = cnt_q;
        lap_active_d = 1'b1;
      end else begin
        lap_active_d = 1'b0;
      end
    end

    if (bus.Clear) begin
      cnt_d        = '0;
      pc_d         = '0;
      done_d       = 1'b0;
      lap_active_d = 1'b0;
    end else if (bus.Load) begin
      cnt_d  = preset;
      pc_d   = '0;
      done_d = 1'b0;
    end else if (bus.Enable) begin
      pc_d = tick ? '0 : pc_q + 1'b1;
      if (tick) begin
        if (!bus.Down) begin
          cnt_d  = up_next;
          wrap_d = up_wrap;
        end else begin
          cnt_d = dn_next;
          if (dn_next == '0) done_d = 1'b1;
        end
      end
    end
  end

  always_ff @(negedge NEclk or negedge Nreset) begin
    if (!Nreset) begin
      cnt_q        <= '0;
      lap_q        <= '0;
      pc_q         <= '0;
      lap_active_q <= 1'b0;
      done_q       <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
      cnt_q        <= cnt_d;
      lap_q        <= lap_d;
      pc_q         <= pc_d;
      lap_active_q <= lap_active_d;
      done_q       <= done_d;
      wrap_q       <= wrap_d;
    end
  end

  assign bus.ms         = lap_active_q ? lap_q.ms  : cnt_q.ms;
  assign bus.s          = lap_active_q ? lap_q.s   : cnt_q.s;
  assign bus.min        = lap_active_q ? lap_q.min : cnt_q.min;
  assign bus.hr         = lap_active_q ? lap_q.hr  : cnt_q.hr;
  assign bus.lap_active = lap_active_q;
  assign bus.done       = done_q;
  assign bus.wrap       = wrap_q;

endmodule

// File: tb/tb_cronometro_lap.sv
// Directed bench for cronometro_lap: a vector table on a DIV=1 instance plus
// hand sequences for async reset and a DIV=4 prescaler instance.
module tb_cronometro_lap;

  logic clk = 1'b1;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  cronometro_lap_if #(.HR_BITS(4)) bus_a ();
  cronometro_lap_if #(.HR_BITS(4)) bus_b ();

  cronometro_lap #(.DIV(1), .HR_BITS(4), .HR_MOD(10)) u_a (
    .NEclk (clk),
    .Nreset(rst_n),
    .bus   (bus_a)
  );

  cronometro_lap #(.DIV(4), .HR_BITS(4), .HR_MOD(10)) u_b (
    .NEclk (clk),
    .Nreset(rst_n),
    .bus   (bus_b)
  );

  typedef struct {
    string name;
    int    en, clr, ld, dn, lap;
    int    phr, pmin, ps, pms;
    int    n;
    int    ehr, emin, es, ems, ela, edone, ewrap;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] mk(int hr, int mi, int s, int ms, int la, int dn, int wr);
    return {3'b000, 4'(hr), 6'(mi), 6'(s), 10'(ms), 1'(la), 1'(dn), 1'(wr)};
  endfunction

  function automatic string fmt(logic [31:0] v);
    return $sformatf("%0d:%0d:%0d.%0d la=%0d done=%0d wrap=%0d",
                     v[28:25], v[24:19], v[18:13], v[12:3], v[2], v[1], v[0]);
  endfunction

  function automatic logic [31:0] st_a();
    return {3'b000, bus_a.hr, bus_a.min, bus_a.s, bus_a.ms, bus_a.lap_active, bus_a.done, bus_a.wrap};
  endfunction

  function automatic logic [31:0] st_b();
    return {3'b000, bus_b.hr, bus_b.min, bus_b.s, bus_b.ms, bus_b.lap_active, bus_b.done, bus_b.wrap};
  endfunction

  function automatic vec_t v(string name, int en, int clr, int ld, int dn, int lap,
                             int phr, int pmin, int ps, int pms, int n,
                             int ehr, int emin, int es, int ems, int ela, int edone, int ewrap);
    vec_t t;
    t.name = name; t.en = en; t.clr = clr; t.ld = ld; t.dn = dn; t.lap = lap;
    t.phr = phr; t.pmin = pmin; t.ps = ps; t.pms = pms; t.n = n;
    t.ehr = ehr; t.emin = emin; t.es = es; t.ems = ems;
    t.ela = ela; t.edone = edone; t.ewrap = ewrap;
    return t;
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %s, expected %s", name, fmt(got), fmt(exp));
    end
  endtask

  // Inputs change 1 time unit after a falling edge, so they are stable well before the next one.
  task automatic edges(int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    {bus_a.Enable, bus_a.Clear, bus_a.Load, bus_a.Down, bus_a.Lap} = '0;
    {bus_b.Enable, bus_b.Clear, bus_b.Load, bus_b.Down, bus_b.Lap} = '0;
    bus_a.pre_ms = '0; bus_a.pre_s = '0; bus_a.pre_min = '0; bus_a.pre_hr = '0;
    bus_b.pre_ms = '0; bus_b.pre_s = '0; bus_b.pre_min = '0; bus_b.pre_hr = '0;
  endtask

  initial begin
    //            name            en clr ld dn lap  hr mi  s   ms     n     hr mi  s   ms  la dn wr
    tbl.push_back(v("clear",         0, 1, 0, 0, 0,  0, 0,  0,   0,     1,   0, 0,  0,   0, 0, 0, 0));
    tbl.push_back(v("up_1000",       1, 0, 0, 0, 0,  0, 0,  0,   0,  1000,   0, 0,  1,   0, 0, 0, 0));
    tbl.push_back(v("up_60000",      1, 0, 0, 0, 0,  0, 0,  0,   0, 59000,   0, 1,  0,   0, 0, 0, 0));
    tbl.push_back(v("load_max",      0, 0, 1, 0, 0,  9, 59, 59, 999,    1,   9, 59, 59, 999, 0, 0, 0));
    tbl.push_back(v("wrap_pulse",    1, 0, 0, 0, 0,  0, 0,  0,   0,     1,   0, 0,  0,   0, 0, 0, 1));
    tbl.push_back(v("wrap_drop",     1, 0, 0, 0, 0,  0, 0,  0,   0,     1,   0, 0,  0,   1, 0, 0, 0));
    tbl.push_back(v("load_cd",       1, 0, 1, 1, 0,  0, 0,  1,   2,     1,   0, 0,  1,   2, 0, 0, 0));
    tbl.push_back(v("cd_done",       1, 0, 0, 1, 0,  0, 0,  0,   0,  1002,   0, 0,  0,   0, 0, 1, 0));
    tbl.push_back(v("cd_hold_zero",  1, 0, 0, 1, 0,  0, 0,  0,   0,     5,   0, 0,  0,   0, 0, 1, 0));
    tbl.push_back(v("cd_clear",      0, 1, 0, 1, 0,  0, 0,  0,   0,     1,   0, 0,  0,   0, 0, 0, 0));
    tbl.push_back(v("load_clamp",    0, 0, 1, 0, 0, 15, 60, 63, 1023,   1,   9, 59, 59, 999, 0, 0, 0));
    tbl.push_back(v("load_borrow",   0, 0, 1, 1, 0,  1, 0,  0,   0,     1,   1, 0,  0,   0, 0, 0, 0));
    tbl.push_back(v("borrow_chain",  1, 0, 0, 1, 0,  0, 0,  0,   0,     1,   0, 59, 59, 999, 0, 0, 0));
    tbl.push_back(v("load_one",      0, 0, 1, 1, 0,  0, 0,  0,   1,     1,   0, 0,  0,   1, 0, 0, 0));
    tbl.push_back(v("cd_last_tick",  1, 0, 0, 1, 0,  0, 0,  0,   0,     1,   0, 0,  0,   0, 0, 1, 0));
    tbl.push_back(v("dir_keeps_done",1, 0, 0, 0, 0,  0, 0,  0,   0,     1,   0, 0,  0,   1, 0, 1, 0));
    tbl.push_back(v("clear2",        0, 1, 0, 0, 0,  0, 0,  0,   0,     1,   0, 0,  0,   0, 0, 0, 0));
    tbl.push_back(v("lap_run",       1, 0, 0, 0, 0,  0, 0,  0,   0,   250,   0, 0,  0, 250, 0, 0, 0));
    tbl.push_back(v("lap_on",        1, 0, 0, 0, 1,  0, 0,  0,   0,     1,   0, 0,  0, 250, 1, 0, 0));
    tbl.push_back(v("lap_hold",      1, 0, 0, 0, 0,  0, 0,  0,   0,    99,   0, 0,  0, 250, 1, 0, 0));
    tbl.push_back(v("lap_off",       1, 0, 0, 0, 1,  0, 0,  0,   0,     1,   0, 0,  0, 351, 0, 0, 0));
    tbl.push_back(v("lap_on_again",  1, 0, 0, 0, 1,  0, 0,  0,   0,     1,   0, 0,  0, 351, 1, 0, 0));
    tbl.push_back(v("clear_over_lap",1, 1, 0, 0, 1,  0, 0,  0,   0,     1,   0, 0,  0,   0, 0, 0, 0));
    tbl.push_back(v("lap_at_zero",   0, 0, 0, 0, 1,  0, 0,  0,   0,     1,   0, 0,  0,   0, 1, 0, 0));
    tbl.push_back(v("load_keeps_lap",0, 0, 1, 0, 0,  0, 0,  5,   0,     1,   0, 0,  0,   0, 1, 0, 0));
    tbl.push_back(v("lap_release",   0, 0, 0, 0, 1,  0, 0,  0,   0,     1,   0, 0,  5,   0, 0, 0, 0));

    idle_inputs();
    #2;
    check("reset_a", st_a(), mk(0, 0, 0, 0, 0, 0, 0));
    check("reset_b", st_b(), mk(0, 0, 0, 0, 0, 0, 0));
    #1 rst_n = 1'b1;

    foreach (tbl[i]) begin
      bus_a.Enable  = 1'(tbl[i].en);
      bus_a.Clear   = 1'(tbl[i].clr);
      bus_a.Load    = 1'(tbl[i].ld);
      bus_a.Down    = 1'(tbl[i].dn);
      bus_a.Lap     = 1'(tbl[i].lap);
      bus_a.pre_hr  = 4'(tbl[i].phr);
      bus_a.pre_min = 6'(tbl[i].pmin);
      bus_a.pre_s   = 6'(tbl[i].ps);
      bus_a.pre_ms  = 10'(tbl[i].pms);
      edges(1);
      bus_a.Clear = 1'b0;
      bus_a.Load  = 1'b0;
      bus_a.Lap   = 1'b0;
      if (tbl[i].n > 1) edges(tbl[i].n - 1);
      check(tbl[i].name, st_a(),
            mk(tbl[i].ehr, tbl[i].emin, tbl[i].es, tbl[i].ems,
               tbl[i].ela, tbl[i].edone, tbl[i].ewrap));
    end

    // Async reset while frozen on a lap, asserted between edges.
    idle_inputs();
    bus_a.pre_s = 6'd3; bus_a.pre_ms = 10'd500; bus_a.Load = 1'b1;
    edges(1);
    bus_a.Load = 1'b0; bus_a.Lap = 1'b1;
    edges(1);
    bus_a.Lap = 1'b0; bus_a.Enable = 1'b1;
    check("lap_before_reset", st_a(), mk(0, 0, 3, 500, 1, 0, 0));
    #3 rst_n = 1'b0;
    #1 check("async_reset", st_a(), mk(0, 0, 0, 0, 0, 0, 0));
    #1 rst_n = 1'b1;
    edges(1);
    check("resume_after_reset", st_a(), mk(0, 0, 0, 1, 0, 0, 0));
    bus_a.Enable = 1'b0;

    // Prescaler on the DIV=4 instance.
    bus_b.Enable = 1'b1;
    edges(3);
    check("div4_no_tick_yet", st_b(), mk(0, 0, 0, 0, 0, 0, 0));
    edges(1);
    check("div4_first_tick", st_b(), mk(0, 0, 0, 1, 0, 0, 0));
    edges(8);
    check("div4_third_tick", st_b(), mk(0, 0, 0, 3, 0, 0, 0));
    edges(2);
    bus_b.Enable = 1'b0;
    edges(10);
    check("div4_paused", st_b(), mk(0, 0, 0, 3, 0, 0, 0));
    bus_b.Enable = 1'b1;
    edges(1);
    check("div4_resume_partial", st_b(), mk(0, 0, 0, 3, 0, 0, 0));
    edges(1);
    check("div4_resume_tick", st_b(), mk(0, 0, 0, 4, 0, 0, 0));
    bus_b.pre_ms = 10'd100; bus_b.Load = 1'b1;
    edges(1);
    bus_b.Load = 1'b0;
    check("div4_load_wins", st_b(), mk(0, 0, 0, 100, 0, 0, 0));
    edges(3);
    check("div4_load_restart", st_b(), mk(0, 0, 0, 100, 0, 0, 0));
    edges(1);
    check("div4_load_tick", st_b(), mk(0, 0, 0, 101, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
